// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM states, parity
// mode constants and the expected-parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP,
        S_WAIT_HIGH
    } rx_state_t;

    // Narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the RX pin plus the bit-decision source.
// With UART_RX_MAJORITY_VOTE_EN defined, the decision is a 2-of-3 vote.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_W        = 7
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Rx_Serial,
    input  logic [CNT_W-1:0] bit_cnt,
    output logic             rx,
    output logic             voted_bit
);

    logic rx_meta;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx      <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote_a, vote_b;

    // The third vote is the live rx value at the decision count.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else begin
            if (bit_cnt == CNT_W'(CLKS_PER_BIT - 3)) vote_a <= rx;
            if (bit_cnt == CNT_W'(CLKS_PER_BIT - 2)) vote_b <= rx;
        end
    end

    assign voted_bit = (vote_a & vote_b) | (vote_a & rx) | (vote_b & rx);
`else
    // The counter only feeds the voter, which this build leaves out.
    logic unused_cnt;
    assign unused_cnt = (^bit_cnt) ^ (CLKS_PER_BIT == 0);
    assign voted_bit  = rx;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: DATA_BITS data, optional parity, 1-2 stop bits,
// with parity/framing/break flags. Optional feature macro: UART_RX_MAJORITY_VOTE_EN.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_SLAST = IDX_W'(STOP_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shadow;
    logic                 par_err, frm_err, all_zero;
    logic                 rx, voted_bit;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_sampler (
        .i_Clock    (i_Clock),
        .i_Reset_n  (i_Reset_n),
        .i_Rx_Serial(i_Rx_Serial),
        .bit_cnt    (bit_cnt),
        .rx         (rx),
        .voted_bit  (voted_bit)
    );

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            shadow       <= '0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            all_zero     <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
            o_Busy       <= 1'b0;
        end else begin
            o_Rx_DV      <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
            case (state)
                S_IDLE: begin
                    bit_cnt  <= '0;
                    bit_idx  <= '0;
                    par_err  <= 1'b0;
                    frm_err  <= 1'b0;
                    all_zero <= 1'b1;
                    if (!rx) begin
                        state  <= S_START;
                        o_Busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_cnt == CNT_HALF) begin
                        bit_cnt <= '0;
                        if (!rx) begin
                            state <= S_DATA;
                        end else begin
                            state  <= S_IDLE;
                            o_Busy <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        // LSB-first shift lands bit 0 in shadow[0] after the last data bit.
                        shadow  <= {voted_bit, shadow[DATA_BITS-1:1]};
                        if (voted_bit) all_zero <= 1'b0;
                        if (bit_idx == IDX_DLAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        if (voted_bit != parity_bit(9'(shadow), PARITY)) par_err <= 1'b1;
                        if (voted_bit) all_zero <= 1'b0;
                        state <= S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        frm_err <= frm_err | ~voted_bit;
                        if (voted_bit) all_zero <= 1'b0;
                        if (bit_idx == IDX_SLAST) begin
                            o_Rx_DV      <= 1'b1;
                            o_Rx_Byte    <= shadow;
                            o_Parity_Err <= par_err;
                            o_Frame_Err  <= frm_err | ~voted_bit;
                            o_Break      <= all_zero & ~voted_bit;
                            state        <= S_CLEANUP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_CLEANUP: begin
                    // A framing error leaves the line possibly low; wait for idle first.
                    state  <= frm_err ? S_WAIT_HIGH : S_IDLE;
                    o_Busy <= frm_err;
                end
                S_WAIT_HIGH: begin
                    if (rx) begin
                        state  <= S_IDLE;
                        o_Busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed scoreboard bench for uart_rx_frame: three instances (8N1, 8E1, 8N2)
// share clock and reset; expected words are queued as frames are driven.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] ser   = 3'b111;
    logic [2:0] dv, perr, ferr, brk, busy;
    logic [7:0] b0, b1, b2;

    exp_t q0[$], q1[$], q2[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_n1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(ser[0]), .o_Rx_DV(dv[0]), .o_Rx_Byte(b0),
        .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Break(brk[0]), .o_Busy(busy[0]));

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_e1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(ser[1]), .o_Rx_DV(dv[1]), .o_Rx_Byte(b1),
        .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Break(brk[1]), .o_Busy(busy[1]));

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(2)) u_n2 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(ser[2]), .o_Rx_DV(dv[2]), .o_Rx_Byte(b2),
        .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Break(brk[2]), .o_Busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic [7:0] b,
                       input logic p, input logic f, input logic k);
        check({nm, " byte"},   32'(b), 32'(e.data));
        check({nm, " parity"}, 32'(p), 32'(e.perr));
        check({nm, " frame"},  32'(f), 32'(e.ferr));
        check({nm, " break"},  32'(k), 32'(e.brk));
    endtask

    // A DV with nothing queued is a spurious frame.
    always @(negedge clk) if (rst_n && dv[0]) begin
        check("n1 dv_expected", 32'(dv[0]), 32'(q0.size() != 0));
        if (q0.size() != 0) cmp("n1", q0.pop_front(), b0, perr[0], ferr[0], brk[0]);
    end
    always @(negedge clk) if (rst_n && dv[1]) begin
        check("e1 dv_expected", 32'(dv[1]), 32'(q1.size() != 0));
        if (q1.size() != 0) cmp("e1", q1.pop_front(), b1, perr[1], ferr[1], brk[1]);
    end
    always @(negedge clk) if (rst_n && dv[2]) begin
        check("n2 dv_expected", 32'(dv[2]), 32'(q2.size() != 0));
        if (q2.size() != 0) cmp("n2", q2.pop_front(), b2, perr[2], ferr[2], brk[2]);
    end

    // Drives bits[0..n-1] LSB first, CPB clocks each; optional 1-cycle spike
    // near the decision sample of bit spike_bit; stops early after max_cyc clocks.
    task automatic send(input int line, input logic [15:0] bits, input int n,
                        input int spike_bit = -1, input int max_cyc = 1 << 20);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < CPB; j++) begin
                if (c == max_cyc) return;
                ser[line] = (i == spike_bit && j == 8) ? ~bits[i] : bits[i];
                @(posedge clk);
                c++;
            end
        end
        ser[line] = 1'b1;
    endtask

    function automatic logic [15:0] fr_n1(input logic [7:0] d);
        return {6'h3f, 1'b1, d, 1'b0};
    endfunction
    function automatic logic [15:0] fr_e1(input logic [7:0] d, input logic p);
        return {5'h1f, 1'b1, p, d, 1'b0};
    endfunction
    function automatic logic [15:0] fr_n2(input logic [7:0] d, input logic s2);
        return {5'h1f, s2, 1'b1, d, 1'b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int k;
        int spk;
        spk = -1;
`ifdef UART_RX_MAJORITY_VOTE_EN
        spk = 4;
`endif
        #2 rst_n = 1'b0;
        idle(3);
        #1;
        check("reset flags", 32'({dv, perr, ferr, brk, busy}), 32'(0));
        check("reset n1 byte", 32'(b0), 32'(0));
        check("reset e1 byte", 32'(b1), 32'(0));
        check("reset n2 byte", 32'(b2), 32'(0));
        @(negedge clk) rst_n = 1'b1;
        idle(4);

        // 8N1 clean frame
        q0.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
        send(0, fr_n1(8'hA5), 10);
        idle(3);
        #1 check("n1 busy after cleanup", 32'(busy[0]), 32'(0));

        // 8E1: wrong then correct parity (0x37 has five ones, even parity bit = 1)
        q1.push_back('{8'h37, 1'b1, 1'b0, 1'b0});
        send(1, fr_e1(8'h37, 1'b0), 11);
        idle(CPB);
        q1.push_back('{8'h37, 1'b0, 1'b0, 1'b0});
        send(1, fr_e1(8'h37, 1'b1), 11);
        idle(CPB);

        // 8N2: second stop bit low, then clean frame
        q2.push_back('{8'h55, 1'b0, 1'b1, 1'b0});
        send(2, fr_n2(8'h55, 1'b0), 11);
        idle(2 * CPB);
        q2.push_back('{8'h12, 1'b0, 1'b0, 1'b0});
        send(2, fr_n2(8'h12, 1'b1), 11);
        idle(CPB);

        // Held-low line: exactly one break event
        q0.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
        ser[0] = 1'b0;
        idle(20 * CPB);
        ser[0] = 1'b1;
        idle(2 * CPB);
        check("n1 busy after break", 32'(busy[0]), 32'(0));
        q0.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
        send(0, fr_n1(8'h3C), 10);
        idle(CPB);

        // Start glitch: no DV, busy drops within CPB/2+3 clocks
        ser[0] = 1'b0;
        idle(4);
        ser[0] = 1'b1;
        #1 check("n1 busy on glitch", 32'(busy[0]), 32'(1));
        k = 0;
        while (busy[0] && k < CPB / 2 + 3) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("n1 busy after glitch", 32'(busy[0]), 32'(0));
        idle(CPB);

        // Reset in the middle of data bit 3
        send(0, fr_n1(8'hC3), 10, -1, 4 * CPB + 8);
        #1 check("n1 busy mid frame", 32'(busy[0]), 32'(1));
        rst_n = 1'b0;
        #1;
        check("n1 outputs in reset", 32'({dv[0], perr[0], ferr[0], brk[0], busy[0]}), 32'(0));
        check("n1 byte in reset", 32'(b0), 32'(0));
        ser[0] = 1'b1;
        idle(3);
        @(negedge clk) rst_n = 1'b1;
        idle(CPB);
        q0.push_back('{8'hC3, 1'b0, 1'b0, 1'b0});
        send(0, fr_n1(8'hC3), 10, spk);

        k = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && k < 4 * CPB) begin
            @(posedge clk);
            k++;
        end
        idle(2 * CPB);
        check("n1 queue drained", 32'(q0.size()), 32'(0));
        check("e1 queue drained", 32'(q1.size()), 32'(0));
        check("n2 queue drained", 32'(q2.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
